// File: rtl/hyperbus_memtest_gen.sv
// Write/read-back memory test generator for a request/response bus; one write then one read per op.
// Define HYPERBUS_MEMTEST_STOP_ON_ERR_EN to end a run right after its first failing response.
module hyperbus_memtest_gen #(
  parameter int unsigned DataWidth = 128,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  logic [CntWidth-1:0]    num_ops_i,
  input  logic [2:0]             size_i,
  input  logic [31:0]            seed_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic                   req_write_o,
  output logic [AddrWidth-1:0]   req_addr_o,
  output logic [2:0]             req_size_o,
  output logic [DataWidth-1:0]   req_wdata_o,
  output logic [DataWidth/8-1:0] req_strb_o,
  input  logic                   rsp_valid_i,
  output logic                   rsp_ready_o,
  input  logic [DataWidth-1:0]   rsp_rdata_i,
  input  logic                   rsp_error_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [CntWidth-1:0]    err_count_o,
  output logic [AddrWidth-1:0]   fail_addr_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam int unsigned Words     = DataWidth / 32;

`ifdef HYPERBUS_MEMTEST_STOP_ON_ERR_EN
  localparam bit StopOnErr = 1'b1;
`else
  localparam bit StopOnErr = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StWrReq, StWrRsp, StRdReq, StRdRsp, StDone} state_e;

  state_e state_q, state_d;

  logic [CntWidth-1:0]  num_q, idx_q;
  logic [AddrWidth-1:0] start_addr, next_addr;
  logic                 start_ok, req_hs, rsp_hs, mismatch, fail, last_op;
  logic                 valid_d, write_d, ready_d, busy_d, done_d;

  // Byte lanes covered by an access of 2**size bytes starting at lane off.
  function automatic logic [StrbWidth-1:0] lane_mask(input logic [OffWidth-1:0] off,
                                                     input logic [2:0] size);
    logic [StrbWidth-1:0] mask;
    int unsigned lo, hi;
    lo = 32'(off);
    hi = lo + (32'd1 << size);
    for (int unsigned b = 0; b < StrbWidth; b++) begin
      mask[b] = (b >= lo) && (b < hi);
    end
    return mask;
  endfunction

  assign start_ok   = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign req_hs     = req_valid_o && req_ready_i;
  assign rsp_hs     = rsp_valid_i && rsp_ready_o;
  assign start_addr = base_addr_i & ~((AddrWidth'(1) << size_i) - AddrWidth'(1));
  assign next_addr  = req_addr_o + (AddrWidth'(1) << req_size_o);
  assign last_op    = ({1'b0, idx_q} + {{CntWidth{1'b0}}, 1'b1}) >= {1'b0, num_q};
  assign fail       = rsp_hs && (rsp_error_i || ((state_q == StRdRsp) && mismatch));

  always_comb begin
    mismatch = 1'b0;
    for (int unsigned b = 0; b < StrbWidth; b++) begin
      if (req_strb_o[b] && (rsp_rdata_i[8*b +: 8] != req_wdata_o[8*b +: 8])) begin
        mismatch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) state_d = (num_ops_i == '0) ? StDone : StWrReq;
      end
      StWrReq: if (req_hs) state_d = StWrRsp;
      StWrRsp: begin
        if (rsp_hs) state_d = (StopOnErr && fail) ? StDone : StRdReq;
      end
      StRdReq: if (req_hs) state_d = StRdRsp;
      StRdRsp: begin
        if (rsp_hs) state_d = ((StopOnErr && fail) || last_op) ? StDone : StWrReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control outputs are decoded from the next state so they leave the flops with the state.
  always_comb begin
    valid_d = 1'b0;
    write_d = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      StWrReq: begin valid_d = 1'b1; write_d = 1'b1; busy_d = 1'b1; end
      StWrRsp: begin ready_d = 1'b1; write_d = 1'b1; busy_d = 1'b1; end
      StRdReq: begin valid_d = 1'b1; busy_d = 1'b1; end
      StRdRsp: begin ready_d = 1'b1; busy_d = 1'b1; end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_valid_o <= 1'b0;
      req_write_o <= 1'b0;
      req_addr_o  <= '0;
      req_size_o  <= '0;
      req_wdata_o <= '0;
      req_strb_o  <= '0;
      rsp_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      err_count_o <= '0;
      fail_addr_o <= '0;
      num_q       <= '0;
      idx_q       <= '0;
    end else begin
      req_valid_o <= valid_d;
      req_write_o <= write_d;
      rsp_ready_o <= ready_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      if (start_ok) begin
        num_q       <= num_ops_i;
        idx_q       <= '0;
        req_size_o  <= size_i;
        req_addr_o  <= start_addr;
        req_strb_o  <= lane_mask(start_addr[OffWidth-1:0], size_i);
        req_wdata_o <= {Words{seed_i}};
        error_o     <= 1'b0;
        err_count_o <= '0;
        fail_addr_o <= '0;
      end else begin
        if (fail) begin
          error_o <= 1'b1;
          if (err_count_o != '1) err_count_o <= err_count_o + CntWidth'(1);
          if (!error_o) fail_addr_o <= req_addr_o;
        end
        if ((state_q == StRdRsp) && (state_d == StWrReq)) begin
          idx_q       <= idx_q + CntWidth'(1);
          req_addr_o  <= next_addr;
          req_strb_o  <= lane_mask(next_addr[OffWidth-1:0], req_size_o);
          req_wdata_o <= {Words{req_wdata_o[31:0] + 32'd1}};
        end
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_memtest_gen.sv
// Randomized bench for hyperbus_memtest_gen: a loopback byte memory answers requests while a
// reference model predicts every request, the failure count and the first failing address.
module tb_hyperbus_memtest_gen;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [31:0]  base_addr_i;
  logic [15:0]  num_ops_i;
  logic [2:0]   size_i;
  logic [31:0]  seed_i;
  logic         req_valid_o, req_ready_i, req_write_o;
  logic [31:0]  req_addr_o;
  logic [2:0]   req_size_o;
  logic [127:0] req_wdata_o;
  logic [15:0]  req_strb_o;
  logic         rsp_valid_i, rsp_ready_o, rsp_error_i;
  logic [127:0] rsp_rdata_i;
  logic         busy_o, done_o, error_o;
  logic [15:0]  err_count_o;
  logic [31:0]  fail_addr_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  hyperbus_memtest_gen dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_ops_i   (num_ops_i),
    .size_i      (size_i),
    .seed_i      (seed_i),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .req_write_o (req_write_o),
    .req_addr_o  (req_addr_o),
    .req_size_o  (req_size_o),
    .req_wdata_o (req_wdata_o),
    .req_strb_o  (req_strb_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_o (rsp_ready_o),
    .rsp_rdata_i (rsp_rdata_i),
    .rsp_error_i (rsp_error_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .err_count_o (err_count_o),
    .fail_addr_o (fail_addr_o)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {req_valid_o, req_write_o, req_size_o, req_addr_o, req_wdata_o, req_strb_o,
                   rsp_ready_o, busy_o, done_o, error_o, err_count_o, fail_addr_o}, '0);
  endtask

  // corrupt_op: op whose read data gets a bad first lane; berr_rsp: response index (2*op for the
  // write, 2*op+1 for the read) returned with a bus error; reset_op: reset while awaiting that read.
  task automatic run_test(input logic [31:0] base, input logic [15:0] num, input logic [2:0] size,
                          input logic [31:0] seed, input int corrupt_op, input int berr_rsp,
                          input bit stall5, input bit poke_start, input int reset_op);
    int first_fail = -1;
    int nfail = 0;
    int exp_reqs;
    int nreq = 0;
    int cycles = 0;
    int pend_k = 0;
    int i;
    bit pending = 1'b0;
    bit hold = 1'b0;
    bit do_reset = 1'b0;
    logic [179:0] prev_req = '0;
    logic [127:0] pend_data = '0;
    logic [127:0] ew, rd;
    logic [31:0]  ea, step, abase;
    logic [31:0]  exp_fail_addr = '0;
    logic [15:0]  es;

    step  = 32'd1 << size;
    abase = base & ~(step - 32'd1);
    for (int k = 0; k < 2 * int'(num); k++) begin
      if ((k == berr_rsp) || ((k % 2 == 1) && (k / 2 == corrupt_op))) begin
        nfail++;
        if (first_fail < 0) first_fail = k;
      end
    end
    exp_reqs = 2 * int'(num);
`ifdef HYPERBUS_MEMTEST_STOP_ON_ERR_EN
    if (first_fail >= 0) begin
      exp_reqs = first_fail + 1;
      nfail    = 1;
    end
`endif
    if (first_fail >= 0) exp_fail_addr = abase + 32'(first_fail / 2) * step;
    mem.delete();

    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = base;
    num_ops_i   = num;
    size_i      = size;
    seed_i      = seed;
    @(posedge clk); #1;
    start_i = 1'b0;
    check_eq("start_valid", req_valid_o, num != 0);
    check_eq("start_busy", busy_o, num != 0);
    check_eq("start_done", done_o, num == 0);
    check_eq("start_clear", {error_o, err_count_o, fail_addr_o}, '0);

    while (!done_o && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (hold) begin
        check_eq("req_hold", {req_write_o, req_size_o, req_addr_o, req_strb_o, req_wdata_o},
                 prev_req);
      end
      hold     = req_valid_o && !req_ready_i;
      prev_req = {req_write_o, req_size_o, req_addr_o, req_strb_o, req_wdata_o};
      if (rsp_valid_i && rsp_ready_o) pending = 1'b0;
      if (req_valid_o && req_ready_i) begin
        i  = nreq / 2;
        ea = abase + 32'(i) * step;
        es = 16'(((32'd1 << step) - 32'd1) << (ea % 32'd16));
        ew = {4{seed + 32'(i)}};
        if (nreq >= exp_reqs) begin
          check_eq("extra_req", nreq, exp_reqs);
        end else begin
          check_eq("req_write", req_write_o, (nreq % 2) == 0);
          check_eq("req_addr", req_addr_o, ea);
          check_eq("req_strb", req_strb_o, es);
          check_eq("req_wdata", req_wdata_o, ew);
          check_eq("req_size", req_size_o, size);
        end
        rd = {$urandom, $urandom, $urandom, $urandom};
        if (nreq % 2 == 0) begin
          for (int l = 0; l < 16; l++) begin
            if (es[l]) mem[(ea & ~32'hF) + 32'(l)] = ew[8*l +: 8];
          end
        end else begin
          for (int l = 0; l < 16; l++) begin
            if (es[l]) rd[8*l +: 8] = mem.exists((ea & ~32'hF) + 32'(l)) ?
                                      mem[(ea & ~32'hF) + 32'(l)] : 8'h00;
          end
          if (i == corrupt_op) rd[8*(ea % 32'd16) +: 8] = rd[8*(ea % 32'd16) +: 8] ^ 8'hA5;
          if (i == reset_op) do_reset = 1'b1;
        end
        pend_data = rd;
        pend_k    = nreq;
        pending   = 1'b1;
        nreq++;
      end

      @(posedge clk); #1;
      if (do_reset) begin
        rst_ni      = 1'b0;
        rsp_valid_i = 1'b0;
        req_ready_i = 1'b0;
        break;
      end
      if (poke_start && cycles == 3) begin
        start_i     = 1'b1;
        base_addr_i = base ^ 32'h100;
        num_ops_i   = num + 16'd3;
        size_i      = 3'($urandom_range(0, 4));
        seed_i      = ~seed;
      end else begin
        start_i = 1'b0;
      end
      req_ready_i = (stall5 && cycles < 5) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      if (pending) begin
        rsp_valid_i = 1'($urandom_range(0, 2) != 0);
        rsp_rdata_i = pend_data;
        rsp_error_i = (pend_k == berr_rsp);
      end else begin
        // Stray responses with an error flag must be ignored outside the response states.
        rsp_valid_i = 1'($urandom_range(0, 1));
        rsp_rdata_i = {$urandom, $urandom, $urandom, $urandom};
        rsp_error_i = 1'b1;
      end
    end

    if (do_reset) begin
      @(posedge clk); #1;
      check_all_zero("mid_reset_outputs");
      rst_ni = 1'b1;
      return;
    end
    start_i     = 1'b0;
    rsp_valid_i = 1'b0;
    req_ready_i = 1'b0;
    check_eq("no_timeout", cycles < 3000, 1'b1);
    check_eq("done", done_o, 1'b1);
    check_eq("busy_end", busy_o, 1'b0);
    check_eq("error", error_o, nfail != 0);
    check_eq("err_count", err_count_o, nfail);
    check_eq("fail_addr", fail_addr_o, exp_fail_addr);
    check_eq("num_reqs", nreq, exp_reqs);
  endtask

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    num_ops_i   = '0;
    size_i      = '0;
    seed_i      = '0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_rdata_i = '0;
    rsp_error_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst_ni = 1'b1;

    run_test(32'h0, 16'd1, 3'd4, 32'hcafe0000, -1, -1, 1'b0, 1'b0, -1);
    run_test(32'h30, 16'd16, 3'd0, $urandom, -1, -1, 1'b0, 1'b0, -1);
    run_test(32'h10, 16'd6, 3'd2, $urandom, 2, -1, 1'b0, 1'b0, -1);
    run_test(32'hFFFF_FFF8, 16'd2, 3'd3, $urandom, -1, -1, 1'b0, 1'b0, -1);
    run_test($urandom, 16'd5, 3'($urandom_range(0, 4)), $urandom, -1, -1, 1'b1, 1'b1, -1);
    run_test($urandom, 16'd5, 3'd2, $urandom, -1, 4, 1'b0, 1'b0, -1);
    run_test($urandom, 16'd4, 3'd1, $urandom, 1, 3, 1'b0, 1'b0, -1);
    run_test($urandom, 16'd3, 3'd2, $urandom, 0, 5, 1'b0, 1'b0, -1);
    run_test($urandom, 16'd0, 3'd2, $urandom, -1, -1, 1'b0, 1'b0, -1);
    run_test($urandom, 16'd6, 3'd2, $urandom, -1, -1, 1'b0, 1'b0, 3);
    for (int t = 0; t < 6; t++) begin
      run_test($urandom, 16'($urandom_range(1, 10)), 3'($urandom_range(0, 4)), $urandom,
               $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 9)) : -1,
               $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 19)) : -1,
               1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hyperbus_memtest_gen.md
HYPERBUS_MEMTEST_GEN -- requirements
Module: hyperbus_memtest_gen

Interface
REQ-001 SHALL have parameter DataWidth, default 128: request/response data width in bits; multiple of 32, at least 32.
REQ-002 SHALL have parameter AddrWidth, default 32: byte address width.
REQ-003 SHALL have parameter CntWidth, default 16: width of the operation and error counters.
REQ-004 SHALL use one clock and a synchronous, active-low reset; clock port clk_i, reset port rst_ni.
REQ-005 Ports, in this order:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  start a test run (pulse)
- base_addr_i  in  AddrWidth  first byte address
- num_ops_i  in  CntWidth  number of write/read pairs
- size_i  in  3  log2 bytes per access; valid range 0..log2(DataWidth/8)
- seed_i  in  32  pattern seed
- req_valid_o  out  1  request valid
- req_ready_i  in  1  request ready
- req_write_o  out  1  1 = write, 0 = read
- req_addr_o  out  AddrWidth  request address
- req_size_o  out  3  request size
- req_wdata_o  out  DataWidth  write data
- req_strb_o  out  DataWidth/8  byte strobe
- rsp_valid_i  in  1  response valid
- rsp_ready_o  out  1  response ready
- rsp_rdata_i  in  DataWidth  read data
- rsp_error_i  in  1  bus error
- busy_o  out  1  run in progress
- done_o  out  1  run finished (sticky)
- error_o  out  1  any mismatch or bus error (sticky)
- err_count_o  out  CntWidth  error count
- fail_addr_o  out  AddrWidth  address of the first failure

Function
REQ-006 SHALL implement the FSM IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE; all outputs are registered.
REQ-007 In IDLE or DONE, start_i=1 SHALL clear done_o, error_o, err_count_o and fail_addr_o, latch all inputs and the op index (set to 0), then go to WR_REQ; with num_ops_i=0 it goes to DONE instead.
REQ-008 start_i SHALL be ignored while busy_o=1; busy_o=1 in the WR_REQ, WR_RSP, RD_REQ and RD_RSP states.
REQ-009 Op address SHALL be (base & ~((1<<size)-1)) + idx*(1<<size), computed modulo 2^AddrWidth, so the address wraps.
REQ-010 req_strb_o SHALL be ((1<<(1<<size))-1) shifted left by addr mod (DataWidth/8).
REQ-011 req_wdata_o SHALL be the 32-bit word (seed + idx) replicated DataWidth/32 times; the same value is used as the read-compare expectation.
REQ-012 req_valid_o SHALL be 1 only in WR_REQ/RD_REQ; it is held with all req_* outputs stable until req_ready_i=1 (no retraction).
REQ-013 The request handshake SHALL move WR_REQ->WR_RSP and RD_REQ->RD_RSP.
REQ-014 rsp_ready_o SHALL be 1 only in WR_RSP/RD_RSP; rsp_valid_i in any other state is ignored.
REQ-015 The write response handshake SHALL move WR_RSP->RD_REQ for the same address.
REQ-016 The read response handshake SHALL compare only strobed bytes.
REQ-017 After the read response, RD_RSP SHALL go to WR_REQ with idx+1 if idx+1 < num_ops, else to DONE.
REQ-018 A failure SHALL be rsp_error_i=1 on any response, or a strobed-byte mismatch on a read.
REQ-019 On each failure, err_count_o SHALL increment, saturating at all-ones, and error_o SHALL be set.
REQ-020 fail_addr_o SHALL capture the address of the first failure only.
REQ-021 A response with both a bus error and a data mismatch SHALL count as one failure.
REQ-022 On entering DONE, done_o SHALL rise on the cycle after the final response handshake.
REQ-023 Latency: req_valid_o SHALL rise on the cycle after start_i is accepted.

Reset
REQ-024 When rst_ni=0 at a clock edge, the block SHALL enter IDLE.
REQ-025 During reset, every output SHALL be 0, including req_valid_o and rsp_ready_o.
REQ-026 Reset mid-run SHALL abandon any outstanding request or response without completing it.

Configuration
REQ-027 With HYPERBUS_MEMTEST_STOP_ON_ERR_EN defined, the first failure SHALL go directly to DONE after its response handshake.
REQ-028 Without HYPERBUS_MEMTEST_STOP_ON_ERR_EN, the run SHALL complete all num_ops and keep counting failures.

Verification
REQ-029 Loopback memory, base=0x0, size=4, num_ops=1, seed=0xcafe0000 -> one write (strb 0xffff, wdata 4x 0xcafe0000), one read; done_o=1, error_o=0.
REQ-030 size=0, base=0x30, num_ops=16 -> strobes 0x0001..0x8000 on addresses 0x30..0x3f; err_count_o=0.
REQ-031 Memory corrupts byte 0 on idx 2, size=2, base=0x10 -> err_count_o=1, fail_addr_o=0x18; with the macro defined, only 3 pairs are issued.
REQ-032 base=0xFFFF_FFF8, size=3, num_ops=2 -> addresses 0xFFFF_FFF8 then 0x0000_0000.
REQ-033 req_ready_i held low for 5 cycles, start_i pulsed during busy, rst_ni low mid-RD_RSP -> req_* outputs stable, start ignored; all outputs 0 and state IDLE on the next cycle.
